// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-gated in-order memory requests, a small
// {pc, instr} queue toward the decoder, and redirect handling that drains stale responses.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic {RUN, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  entry_t           fifo_q [QDEPTH];
  entry_t           fifo_d [QDEPTH];

  logic             resp_c, pop_c, push_c, issue_c;
  logic [SUM_W-1:0] used_c;
  logic [31:0]      redirect_tgt_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == QDEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state: credits, response routing, queue and redirect/drain control
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_d     = fifo_q;

    redirect_tgt_c = redirect_pc & ~32'h3;
    // Responses with nothing outstanding are protocol errors and are ignored
    resp_c  = imem_valid && (outst_q != '0);
    pop_c   = (count_q != '0) && instr_ready && !redirect;
    // A pop this cycle frees a slot immediately so the stream stays gap-free
    used_c  = SUM_W'(outst_q) + SUM_W'(count_q) - SUM_W'(pop_c);
    issue_c = (state_q == RUN) && !redirect && (used_c < SUM_W'(QDEPTH));
    push_c  = resp_c && !redirect && (discard_q == '0);

    outst_d = outst_q + CNT_W'(issue_c) - CNT_W'(resp_c);
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    if (issue_c) fetch_pc_d = fetch_pc_q + 32'd4;
    if (resp_c && !redirect && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);

    // resp_pc tracks the address of the next response that will be kept
    if (push_c) begin
      fifo_d[wr_ptr_q] = '{pc: resp_pc_q, instr: imem_rdata};
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      resp_pc_d        = resp_pc_q + 32'd4;
    end
    if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);

    if (redirect) begin
      fetch_pc_d = redirect_tgt_c;
      resp_pc_d  = redirect_tgt_c;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      discard_d  = outst_d;
      state_d    = (outst_d != '0) ? DRAIN : RUN;
    end else if ((state_q == DRAIN) && (discard_d == '0)) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_q     <= fifo_d;
    end
  end

  assign imem_req    = issue_c && !rst;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr_o     = instr_valid ? fifo_q[rd_ptr_q].instr : '0;
  assign pc_o        = instr_valid ? fifo_q[rd_ptr_q].pc    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with variable latency, scoreboard of
// expected {pc, instr}, directed reset/stall/redirect scenarios and a random phase.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_valid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr_o, pc_o;
  logic        imem_req2, imem_valid2, instr_valid2;
  logic [31:0] imem_addr2, imem_rdata2, instr_o2, pc_o2;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC), .QDEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_o(instr_o), .pc_o(pc_o)
  );

  instr_fetch #(.RESET_PC(RST_PC2), .QDEPTH(2)) u_dut_wrap (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_valid2), .imem_rdata(imem_rdata2), .redirect(1'b0),
    .redirect_pc(32'h0), .instr_valid(instr_valid2), .instr_ready(1'b1),
    .instr_o(instr_o2), .pc_o(pc_o2)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] q2[$];
  int          cyc, n_vec, n_err, lat, redirect_cyc, last_stale_cyc, req_count, gap_cnt;
  bit          seen_valid, await_first, watch_pc, first_after_rst, collect2, req2_prev;
  logic [31:0] exp_addr, redir_tgt, addr2_prev;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample, score, record requests
  task automatic step();
    pend_t r;
    exp_t  e;
    bit    have_resp, resp_stale;
    int    n_stale, exp_cyc;
    have_resp  = 1'b0;
    resp_stale = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      r          = pend.pop_front();
      have_resp  = 1'b1;
      resp_stale = r.stale || redirect || rst;
      imem_valid = 1'b1;
      imem_rdata = mem_word(r.addr);
    end
    imem_valid2 = req2_prev;
    imem_rdata2 = mem_word(addr2_prev);
    #1;
    if (!rst) begin
      check_eq("valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (seen_valid && !instr_valid) gap_cnt++;
      if (instr_valid) seen_valid = 1'b1;
      if (instr_valid && instr_ready && !redirect && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("pc", pc_o, e.pc);
        check_eq("instr", instr_o, e.instr);
        if (watch_pc) begin
          check_eq("first_pc", pc_o, redir_tgt);
          watch_pc = 1'b0;
        end
      end
      if (first_after_rst) begin
        check_eq("req_after_rst", 32'(imem_req), 32'd1);
        first_after_rst = 1'b0;
      end
    end
    if (redirect && !rst) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_q.delete();
      redir_tgt    = {redirect_pc[31:2], 2'b00};
      exp_addr     = redir_tgt;
      redirect_cyc = cyc;
      await_first  = 1'b1;
      watch_pc     = 1'b1;
    end
    if (rst) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_q.delete();
      exp_addr    = RST_PC;
      await_first = 1'b0;
      watch_pc    = 1'b0;
    end
    if (have_resp) begin
      if (resp_stale) last_stale_cyc = cyc;
      else exp_q.push_back('{r.addr, mem_word(r.addr)});
    end
    if (!rst && imem_req) begin
      req_count++;
      check_eq("addr", imem_addr, exp_addr);
      if (await_first) begin
        n_stale = 0;
        foreach (pend[i]) if (pend[i].stale) n_stale++;
        check_eq("stale_pending", 32'(n_stale), 32'd0);
        exp_cyc = ((last_stale_cyc > redirect_cyc) ? last_stale_cyc : redirect_cyc) + 1;
        check_eq("drain_exit", 32'(cyc), 32'(exp_cyc));
        await_first = 1'b0;
      end
      pend.push_back('{imem_addr, cyc + lat, 1'b0});
      exp_addr = exp_addr + 32'd4;
    end
    req2_prev  = imem_req2 && !rst;
    addr2_prev = imem_addr2;
    if (!rst && imem_req2 && collect2 && q2.size() < 3) q2.push_back(imem_addr2);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step();
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr_o, 32'd0);
    check_eq("rst_pc", pc_o, 32'd0);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    repeat (n - 1) step();
    rst = 1'b0;
    first_after_rst = 1'b1;
  endtask

  initial begin
    int          start;
    bit          found;
    logic [31:0] exp2 [3];
    exp2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    rst = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_rdata = '0; imem_valid2 = 1'b0; imem_rdata2 = '0;
    cyc = 0; n_vec = 0; n_err = 0; lat = 1; redirect_cyc = 0; last_stale_cyc = 0;
    req_count = 0; gap_cnt = 0; seen_valid = 1'b0; await_first = 1'b0; watch_pc = 1'b0;
    first_after_rst = 1'b0; req2_prev = 1'b0; addr2_prev = '0; exp_addr = RST_PC;
    redir_tgt = '0; collect2 = 1'b1;

    // Reset release and 1-cycle streaming; wrapping instance runs alongside
    do_reset(3);
    seen_valid = 1'b0; gap_cnt = 0;
    repeat (30) step();
    check_eq("stream_started", 32'(seen_valid), 32'd1);
    check_eq("stream_gaps", 32'(gap_cnt), 32'd0);
    check_eq("wrap_count", 32'(q2.size()), 32'd3);
    if (q2.size() == 3) for (int i = 0; i < 3; i++) check_eq("wrap_addr", q2[i], exp2[i]);
    collect2 = 1'b0;

    // Decoder stall from a clean start: queue fills with exactly two requests
    do_reset(4);
    instr_ready = 1'b0;
    start = req_count;
    repeat (10) step();
    check_eq("stall_reqs", 32'(req_count - start), 32'd2);
    check_eq("stall_req_low", 32'(imem_req), 32'd0);
    instr_ready = 1'b1;
    #1;
    check_eq("req_on_pop", 32'(imem_req), 32'd1);
    repeat (20) step();

    // Redirect to an unaligned target with two requests in flight
    lat = 3; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pend.size() == 2 && pend[0].due > cyc) found = 1'b1;
      else step();
    end
    check_eq("t3_setup", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check_eq("flush_empty", 32'(instr_valid), 32'd0);
    repeat (25) step();
    check_eq("t3_refetch", 32'(await_first), 32'd0);
    check_eq("t3_first_pc_seen", 32'(watch_pc), 32'd0);

    // Redirect colliding with a response and a would-be pop
    lat = 1; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pend.size() != 0 && pend[0].due <= cyc && instr_valid) found = 1'b1;
      else step();
    end
    check_eq("t4_setup", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h2000_0040;
    step();
    redirect = 1'b0;
    repeat (20) step();
    check_eq("t4_refetch", 32'(await_first), 32'd0);

    // Reset with two requests in flight; late responses must never surface
    lat = 3; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pend.size() == 2) found = 1'b1;
      else step();
    end
    check_eq("t6_setup", 32'(found), 32'd1);
    do_reset(4);
    repeat (20) step();

    // Random backpressure, latency and redirects
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      lat         = $urandom_range(1, 3);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = $urandom;
      step();
    end
    redirect = 1'b0; instr_ready = 1'b1;
    repeat (15) step();
    check_eq("rand_refetch", 32'(await_first), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
